// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage.
package mem_stage_pkg;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int unsigned DST_LSB = 0;
    localparam int unsigned DST_W   = 4;
    localparam int unsigned WE_BIT  = 4;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Local data RAM: synchronous write with enable, asynchronous read registered by the parent.
module mem_stage_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [15:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: multi-cycle load/store to a local RAM, stalls upstream while busy,
// and drives registered MEM/WB outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LAT    = 2
) (
    input  logic        C,
    input  logic        R,
    input  logic        IV,
    input  logic [15:0] IU,
    input  logic [15:0] IL,
    input  logic [15:0] IW,
    input  logic [7:0]  IB,
    input  logic [1:0]  IC,
    output logic [15:0] OD,
    output logic [15:0] OW,
    output logic [7:0]  OB,
    output logic        OV,
    output logic        S
);

    // Cycles left in WAIT after the first (stalled) cycle in IDLE.
    localparam logic [3:0] CntInit = 4'((LAT >= 2) ? LAT - 2 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] od_q, od_d;
    logic [15:0] ow_q, ow_d;
    logic [7:0]  ob_q, ob_d;
    logic        ov_q, ov_d;
    logic        stall;
    logic        retire;
    logic        ram_we;
    logic [15:0] ram_rdata;

    mem_stage_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (C),
        .we_i   (ram_we),
        .addr_i (IU[ADDR_W-1:0]),
        .wdata_i(IL),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        od_d    = od_q;
        ow_d    = ow_q;
        ob_d    = ob_q;
        ov_d    = 1'b0;
        stall   = 1'b0;
        retire  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (IV) begin
                    if (!is_mem_op(IC)) begin
                        od_d = IU;
                        ow_d = IW;
                        ob_d = IB;
                        ov_d = 1'b1;
                    end else if (LAT == 1) begin
                        retire = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inputs are held through WAIT, so IC/IU/IL still describe the access here.
        if (retire) begin
            od_d = (IC == OP_LOAD) ? ram_rdata : IU;
            ow_d = IW;
            ob_d = IB;
            if (IC == OP_STORE) begin
                ob_d[WE_BIT] = 1'b0;
            end
            ov_d = 1'b1;
        end
    end

    // Reset at the completion edge aborts the store.
    assign ram_we = retire && (IC == OP_STORE) && !R;
    assign S      = stall && !R;

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            od_q    <= 16'd0;
            ow_q    <= 16'd0;
            ob_q    <= 8'd0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            od_q    <= od_d;
            ow_q    <= ow_d;
            ob_q    <= ob_d;
            ov_q    <= ov_d;
        end
    end

    assign OD = od_q;
    assign OW = ow_q;
    assign OB = ob_q;
    assign OV = ov_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three builds (LAT=2, 1, 4) driven with directed and random traffic.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [15:0] od;
        logic [15:0] ow;
        logic [7:0]  ob;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done [3];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int unsigned LAT     = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        localparam int unsigned ABORT_N = (LAT >= 3) ? LAT - 2 : LAT - 1;

        logic        r, iv, ov, s;
        logic [15:0] iu, il, iw, od, ow;
        logic [7:0]  ib, ob;
        logic [1:0]  ic;

        exp_t        q[$];
        logic [15:0] mem_model [256];
        bit          in_reset = 1'b1;
        logic [15:0] last_od, last_ow;
        logic [7:0]  last_ob;

        mem_stage #(
            .ADDR_W(8),
            .LAT   (LAT)
        ) dut (
            .C (clk),
            .R (r),
            .IV(iv),
            .IU(iu),
            .IL(il),
            .IW(iw),
            .IB(ib),
            .IC(ic),
            .OD(od),
            .OW(ow),
            .OB(ob),
            .OV(ov),
            .S (s)
        );

        function automatic string nm(input string n);
            return $sformatf("lat%0d_%s", LAT, n);
        endfunction

        // Present one entry, hold it while stalled, and record the expected retirement.
        task automatic issue(input logic [1:0] op, input logic [15:0] u, input logic [15:0] l,
                             input logic [15:0] w, input logic [7:0] b);
            int         stall;
            exp_t       e;
            logic [7:0] a;
            bit         mem;
            stall = 0;
            iv = 1'b1; ic = op; iu = u; il = l; iw = w; ib = b;
            forever begin
                @(negedge clk);
                if (!s) break;
                stall++;
                if (stall > 20) break;
            end
            mem = (op == OP_LOAD) || (op == OP_STORE);
            check(nm("stall_cycles"), 16'(stall), mem ? 16'(LAT - 1) : 16'd0);
            a    = u[7:0];
            e.od = u;
            e.ow = w;
            e.ob = b;
            if (op == OP_LOAD) e.od = mem_model[a];
            if (op == OP_STORE) begin
                mem_model[a] = l;
                e.ob[4] = 1'b0;
            end
            q.push_back(e);
            @(posedge clk);
            #1;
        endtask

        task automatic idle();
            iv = 1'b0;
            ic = 2'($urandom);
            iu = 16'($urandom);
            il = 16'($urandom);
            iw = 16'($urandom);
            ib = 8'($urandom);
            @(posedge clk);
            #1;
        endtask

        task automatic check_cleared();
            @(negedge clk);
            check(nm("rst_od"), od, 16'h0000);
            check(nm("rst_ow"), ow, 16'h0000);
            check(nm("rst_ob"), 16'(ob), 16'h0000);
            check(nm("rst_ov"), 16'(ov), 16'h0000);
            last_od = 16'h0000;
            last_ow = 16'h0000;
            last_ob = 8'h00;
            @(posedge clk);
            #1;
            in_reset = 1'b0;
        endtask

        task automatic rst_with(input logic [1:0] op, input logic [15:0] u, input logic [15:0] l);
            in_reset = 1'b1;
            r = 1'b1; iv = 1'b1; ic = op; iu = u; il = l; iw = 16'h5A5A; ib = 8'hFF;
            repeat (2) begin
                @(negedge clk);
                check(nm("s_in_reset"), 16'(s), 16'd0);
                @(posedge clk);
                #1;
            end
            r = 1'b0;
            iv = 1'b0;
            q.delete();
            check_cleared();
        endtask

        // Reset arrives before the store's completion edge, so nothing may be written.
        task automatic abort_store(input logic [15:0] u, input logic [15:0] l);
            in_reset = 1'b1;
            iv = 1'b1; ic = OP_STORE; iu = u; il = l; iw = 16'h0BAD; ib = 8'h10;
            repeat (ABORT_N) begin
                @(posedge clk);
                #1;
            end
            r = 1'b1;
            @(negedge clk);
            check(nm("s_abort"), 16'(s), 16'd0);
            @(posedge clk);
            #1;
            r = 1'b0;
            iv = 1'b0;
            q.delete();
            check_cleared();
        endtask

        always @(negedge clk) begin
            exp_t e;
            if (!in_reset) begin
                if (ov) begin
                    if (q.size() == 0) begin
                        check(nm("unexpected_ov"), 16'(ov), 16'd0);
                    end else begin
                        e = q.pop_front();
                        check(nm("od"), od, e.od);
                        check(nm("ow"), ow, e.ow);
                        check(nm("ob"), 16'(ob), 16'(e.ob));
                        last_od = e.od;
                        last_ow = e.ow;
                        last_ob = e.ob;
                    end
                end else begin
                    check(nm("hold_od"), od, last_od);
                    check(nm("hold_ow"), ow, last_ow);
                    check(nm("hold_ob"), 16'(ob), 16'(last_ob));
                end
            end
        end

        initial begin
            rst_with(OP_STORE, 16'h0012, 16'hDEAD);
            // Seed every word so later loads have a known value; 0x20 stays zero.
            for (int i = 0; i < 256; i++) begin
                issue(OP_STORE, 16'(i), (i == 32) ? 16'h0000 : 16'($urandom),
                      16'($urandom), 8'($urandom));
            end
            idle();
            rst_with(OP_STORE, 16'h0077, 16'hAAAA);
            issue(OP_LOAD, 16'h0077, 16'h0000, 16'h1111, 8'h15);

            issue(OP_NONE, 16'hF230, 16'h0000, 16'hF500, 8'hF6);
            idle();
            issue(OP_STORE, 16'h0012, 16'hF400, 16'h2222, 8'h1A);
            issue(OP_LOAD, 16'h0012, 16'h0000, 16'h3333, 8'h13);
            issue(OP_STORE, 16'h0105, 16'hBEEF, 16'h4444, 8'h17);
            issue(OP_LOAD, 16'h0005, 16'h0000, 16'h5555, 8'h18);
            idle();

            abort_store(16'h0020, 16'h1234);
            issue(OP_LOAD, 16'h0020, 16'h0000, 16'h6666, 8'h11);

            for (int i = 0; i < 8; i++) begin
                issue(OP_STORE, 16'h0003, 16'(i * 16'h1111 + 7), 16'(i), 8'h1F);
                issue(OP_LOAD, 16'h0003, 16'hFFFF, 16'(i + 100), 8'h12);
            end
            issue(OP_RSVD, 16'hABCD, 16'h1357, 16'h2468, 8'h9C);

            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                end else begin
                    issue(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          8'($urandom));
                end
            end
            repeat (LAT + 3) idle();
            check(nm("queue_drain"), 16'(q.size()), 16'd0);
            done[gi] = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(done[0] && done[1] && done[2]) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        check("all_done", {13'd0, done[2], done[1], done[0]}, 16'h0007);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
